// File: rtl/jtopl_pg_ring.sv
// jtopl_pg_ring: OPL phase generator slot sequencer and per-slot phase store.
// Walks the 18 operator slots, forms the pure phase increment from fnum/block,
// detects key-on edges per slot and keeps an 18-deep circular phase store that
// feeds the external phase adder (jtopl_pg_sum) and takes its result back.
// Optional feature macro: JTOPL_PG_VIB_EN (vibrato offset on fnum).
module jtopl_pg_ring (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic [9:0]  fnum,
  input  logic [2:0]  block,
  input  logic [3:0]  mul,
  input  logic        keyon,
  input  logic        vib_en,
  input  logic        vib_dep,
  input  logic [18:0] phase_out,
  output logic [4:0]  slot,
  output logic        zero,
  output logic [16:0] phinc_pure,
  output logic [3:0]  mul_I,
  output logic        pg_rst,
  output logic [18:0] phase_in,
  output logic [9:0]  phase_op
);

  // Clamp a signed modulated F-number into the legal 0..1023 range.
  function automatic logic [9:0] sat_fnum(input logic signed [11:0] v);
    if (v < 0)
      sat_fnum = 10'd0;
    else if (v > 12'sd1023)
      sat_fnum = 10'd1023;
    else
      sat_fnum = v[9:0];
  endfunction

  logic [9:0]  fmod_p0;
  logic [16:0] inc_p0;
  logic [17:0] kon_prev;
  logic [18:0] store [0:17];

  // Slot counter: 0..17, one step per enabled cycle.
  always_ff @(posedge clk) begin
    if (rst)
      slot <= 5'd0;
    else if (cen)
      slot <= (slot == 5'd17) ? 5'd0 : slot + 5'd1;
  end

  assign zero = (slot == 5'd0);

  // ---- stage 0: combinational frequency modulation and increment ----
`ifdef JTOPL_PG_VIB_EN
  logic [12:0]        vib_cnt;
  logic [2:0]         vib_pos;
  logic [2:0]         vib_b;
  logic [2:0]         vib_half;
  logic signed [11:0] vib_off_p0;
  logic signed [11:0] fsum_p0;

  // Vibrato position counter, one tick per full 18-slot sample.
  always_ff @(posedge clk) begin
    if (rst)
      vib_cnt <= 13'd0;
    else if (cen && slot == 5'd17)
      vib_cnt <= vib_cnt + 13'd1;
  end

  assign vib_pos = vib_cnt[12:10];

  // Triangle-shaped offset derived from the top fnum bits and depth select.
  always_comb begin
    vib_b      = vib_dep ? fnum[9:7] : (fnum[9:7] >> 1);
    vib_half   = vib_b >> 1;
    vib_off_p0 = 12'sd0;
    case (vib_pos)
      3'd1, 3'd3: vib_off_p0 =  $signed({9'd0, vib_half});
      3'd2:       vib_off_p0 =  $signed({9'd0, vib_b});
      3'd5, 3'd7: vib_off_p0 = -$signed({9'd0, vib_half});
      3'd6:       vib_off_p0 = -$signed({9'd0, vib_b});
      default:    vib_off_p0 = 12'sd0;
    endcase
    if (!vib_en)
      vib_off_p0 = 12'sd0;
    fsum_p0 = $signed({2'b00, fnum}) + vib_off_p0;
    fmod_p0 = sat_fnum(fsum_p0);
  end
`else
  logic unused_vib;
  assign unused_vib = vib_en ^ vib_dep;
  assign fmod_p0    = fnum;
`endif

  // Octave shift; 10 bits shifted by at most 7 always fits in 17 bits.
  assign inc_p0 = ({7'b0, fmod_p0} << block) >> 1;

  // ---- stage I: registered increment, multiplier and key-on edge ----
  always_ff @(posedge clk) begin
    if (rst) begin
      phinc_pure <= 17'd0;
      mul_I      <= 4'd0;
      pg_rst     <= 1'b0;
      kon_prev   <= 18'd0;
      phase_op   <= 10'd0;
    end else if (cen) begin
      phinc_pure     <= inc_p0;
      mul_I          <= mul;
      pg_rst         <= keyon & ~kon_prev[slot];
      kon_prev[slot] <= keyon;
      phase_op       <= phase_out[18:9];
    end
  end

  // ---- phase store: 18-entry delay line closing the per-slot loop ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 18; i++)
        store[i] <= 19'd0;
    end else if (cen) begin
      store[0] <= phase_out;
      for (int i = 1; i < 18; i++)
        store[i] <= store[i-1];
    end
  end

  // Oldest entry belongs to the slot currently held in stage I.
  assign phase_in = store[17];

endmodule

// File: tb/tb_jtopl_pg_ring.sv
// Testbench for jtopl_pg_ring with an attached behavioural phase adder and a
// per-slot reference model of phase accumulation and key-on detection.
module tb_jtopl_pg_ring;

  logic        rst = 1'b1;
  logic        clk = 1'b0;
  logic        cen = 1'b0;
  logic [9:0]  fnum = '0;
  logic [2:0]  block = '0;
  logic [3:0]  mul = '0;
  logic        keyon = 1'b0;
  logic        vib_en = 1'b0;
  logic        vib_dep = 1'b0;
  logic [18:0] phase_out;
  logic [4:0]  slot;
  logic        zero;
  logic [16:0] phinc_pure;
  logic [3:0]  mul_I;
  logic        pg_rst;
  logic [18:0] phase_in;
  logic [9:0]  phase_op;

  int checks = 0;
  int failures = 0;

  jtopl_pg_ring dut (
    .rst(rst), .clk(clk), .cen(cen), .fnum(fnum), .block(block), .mul(mul),
    .keyon(keyon), .vib_en(vib_en), .vib_dep(vib_dep), .phase_out(phase_out),
    .slot(slot), .zero(zero), .phinc_pure(phinc_pure), .mul_I(mul_I),
    .pg_rst(pg_rst), .phase_in(phase_in), .phase_op(phase_op)
  );

  always #5 clk = ~clk;

  // OPL multiplier table in half units (code 0 = x0.5).
  function automatic int mulv(input logic [3:0] m);
    case (m)
      4'd0: mulv = 1;   4'd1: mulv = 2;   4'd2: mulv = 4;   4'd3: mulv = 6;
      4'd4: mulv = 8;   4'd5: mulv = 10;  4'd6: mulv = 12;  4'd7: mulv = 14;
      4'd8: mulv = 16;  4'd9: mulv = 18;  4'd10: mulv = 20; 4'd11: mulv = 20;
      4'd12: mulv = 24; 4'd13: mulv = 24; 4'd14: mulv = 30; default: mulv = 30;
    endcase
  endfunction

  // Attached adder: key-on forces phase to zero, otherwise accumulate mod 2^19.
  logic [31:0] add_d;
  always_comb begin
    add_d     = (32'(phinc_pure) * 32'(mulv(mul_I))) >> 1;
    phase_out = pg_rst ? 19'd0 : phase_in + add_d[18:0];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: one phase per slot, previous key-on per slot, and the
  // parameters of the slot currently waiting for its adder result.
  int          m_ph [18];
  bit          m_kp [18];
  int          m_slot;
  int          st_slot;
  int          st_inc;
  int          st_mul;
  bit          st_rst;
  int          m_op;

  // Per-slot parameters presented whenever that slot is selected.
  logic [9:0]  p_fnum [18];
  logic [2:0]  p_block [18];
  logic [3:0]  p_mul [18];
  bit          p_key [18];

  int          kon_pulses;

  task automatic model_reset();
    for (int i = 0; i < 18; i++) begin
      m_ph[i] = 0;
      m_kp[i] = 1'b0;
    end
    m_slot  = 0;
    st_slot = 17;
    st_inc  = 0;
    st_mul  = 0;
    st_rst  = 1'b0;
    m_op    = 0;
  endtask

  task automatic step(input bit c, input bit r, input logic [9:0] f,
                      input logic [2:0] b, input logic [3:0] m, input bit k);
    int np;
    @(negedge clk);
    cen = c; rst = r; fnum = f; block = b; mul = m; keyon = k;
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else if (c) begin
      np = st_rst ? 0 : (m_ph[st_slot] + (st_inc * mulv(4'(st_mul))) / 2) % (1 << 19);
      m_ph[st_slot] = np;
      m_op    = np / 512;
      st_slot = m_slot;
      st_inc  = (int'(f) * (1 << b)) / 2;
      st_mul  = int'(m);
      st_rst  = k && !m_kp[m_slot];
      m_kp[m_slot] = k;
      m_slot  = (m_slot + 1) % 18;
      if (pg_rst) kon_pulses++;
    end
    chk("slot", 32'(slot), 32'(m_slot));
    chk("zero", 32'(zero), 32'(m_slot == 0));
    chk("phinc_pure", 32'(phinc_pure), 32'(st_inc));
    chk("mul_I", 32'(mul_I), 32'(st_mul));
    chk("pg_rst", 32'(pg_rst), 32'(st_rst));
    chk("phase_in", 32'(phase_in), 32'(m_ph[st_slot]));
    chk("phase_op", 32'(phase_op), 32'(m_op));
  endtask

  // n enabled cycles; with gaps, random idle cycles carrying junk inputs.
  task automatic run(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int idle;
        idle = int'($urandom_range(0, 3));
        for (int j = 0; j < idle; j++)
          step(1'b0, 1'b0, 10'($urandom), 3'($urandom), 4'($urandom), 1'($urandom));
      end
      step(1'b1, 1'b0, p_fnum[m_slot], p_block[m_slot], p_mul[m_slot], p_key[m_slot]);
    end
  endtask

  task automatic clear_params();
    for (int i = 0; i < 18; i++) begin
      p_fnum[i] = '0; p_block[i] = '0; p_mul[i] = '0; p_key[i] = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    clear_params();
    kon_pulses = 0;

    // Reset state
    step(1'b0, 1'b1, '0, '0, '0, 1'b0);
    step(1'b0, 1'b1, '0, '0, '0, 1'b0);
    chk("rst_slot", 32'(slot), 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);

    // Slot 5 accumulation, back-to-back enables
    p_fnum[5] = 10'h200; p_block[5] = 3'd4; p_mul[5] = 4'd1;
    run(42, 1'b0);
    chk("tp_phinc", 32'(phinc_pure), 32'd4096);
    chk("tp_phase_in", 32'(phase_in), 32'd8192);
    run(1, 1'b0);
    chk("tp_phase_op", 32'(phase_op), 32'd24);

    // Key-on edge on slot 5 held high: a single pulse
    kon_pulses = 0;
    p_key[5] = 1'b1;
    run(54, 1'b1);
    chk("kon_single", 32'(kon_pulses), 32'd1);

    // Randomized parameters, key toggles and enable gaps
    for (int i = 0; i < 18; i++) begin
      p_fnum[i] = 10'($urandom); p_block[i] = 3'($urandom);
      p_mul[i] = 4'($urandom); p_key[i] = 1'($urandom);
    end
    for (int r = 0; r < 30; r++) begin
      p_key[$urandom_range(0, 17)] ^= 1'b1;
      p_fnum[$urandom_range(0, 17)] = 10'($urandom);
      run(18, r[0]);
    end

    // Maximum increment, phase wraps continuously
    for (int i = 0; i < 18; i++) begin
      p_fnum[i] = 10'd1023; p_block[i] = 3'd7; p_mul[i] = 4'd15;
    end
    run(180, 1'b0);
    chk("max_phinc", 32'(phinc_pure), 32'd65472);

    // Reset asserted together with an enable at slot 9
    while (m_slot != 9) run(1, 1'b0);
    step(1'b1, 1'b1, 10'd1023, 3'd7, 4'd15, 1'b0);
    chk("mid_rst_slot", 32'(slot), 32'd0);
    for (int i = 0; i < 18; i++) begin
      run(1, 1'b0);
      chk("post_rst_phase_in", 32'(phase_in), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
